// File: rtl/voice_allocator.sv
// voice_allocator: maps note-on/off events onto synth voice slots, lowest free first,
// round-robin steal when full, in-place retrigger for a key already held.
module voice_allocator #(
  parameter int NUM_CHANNELS = 16,
  parameter int NUM_BITS = 32,
  parameter int NOTE_BITS = 7,
  localparam int CW = $clog2(NUM_CHANNELS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           evt_valid,
  output logic                           evt_ready,
  input  logic                           evt_on,
  input  logic [NOTE_BITS-1:0]           evt_note,
  input  logic [NUM_BITS-1:0]            evt_vel,
  input  logic [NUM_BITS-1:0]            evt_car,
  input  logic [NUM_BITS-1:0]            evt_mod,
  input  logic [NUM_CHANNELS-1:0]        available,
  output logic [NUM_BITS*NUM_CHANNELS-1:0] carrier_out,
  output logic [NUM_BITS*NUM_CHANNELS-1:0] modulator_out,
  output logic [NUM_BITS*NUM_CHANNELS-1:0] velocity_out,
  output logic [NUM_CHANNELS-1:0]        gate_out,
  output logic                           steal_pulse,
  output logic                           miss_pulse
);
  typedef enum logic [1:0] {S_INIT, S_IDLE, S_SCAN, S_COMMIT} state_t;
  localparam logic [CW-1:0] LAST = CW'(NUM_CHANNELS - 1);
  state_t r_state, w_next;
  logic [CW-1:0] r_idx, r_match_idx, r_free_idx, r_steal_ptr, w_ch;
  logic r_on, r_match, r_free, w_hit, w_vacant;
  logic [NOTE_BITS-1:0] r_note;
  logic [NUM_BITS-1:0] r_vel, r_car, r_mod;
  logic [NOTE_BITS-1:0] r_note_tab [NUM_CHANNELS];
  assign evt_ready = r_state == S_IDLE;
  assign w_hit = gate_out[r_idx] && r_note_tab[r_idx] == r_note;
  assign w_vacant = !gate_out[r_idx] && available[r_idx];
  assign w_ch = r_match ? r_match_idx : r_free ? r_free_idx : r_steal_ptr;
  always_comb begin
    w_next = r_state;
    w_next = r_state == S_INIT ? S_IDLE :
             r_state == S_IDLE ? (evt_valid ? S_SCAN : S_IDLE) :
             r_state == S_SCAN ? (r_idx == LAST ? S_COMMIT : S_SCAN) : S_IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= S_INIT;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx <= '0;
      r_match_idx <= '0;
      r_free_idx <= '0;
      r_steal_ptr <= '0;
      r_on <= 1'b0;
      r_match <= 1'b0;
      r_free <= 1'b0;
      r_note <= '0;
      r_vel <= '0;
      r_car <= '0;
      r_mod <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) r_note_tab[i] <= '0;
      carrier_out <= '0;
      modulator_out <= '0;
      velocity_out <= '0;
      gate_out <= '0;
      steal_pulse <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      steal_pulse <= 1'b0;
      miss_pulse <= 1'b0;
      if (r_state == S_IDLE && evt_valid) begin
        r_on <= evt_on;
        r_note <= evt_note;
        r_vel <= evt_vel;
        r_car <= evt_car;
        r_mod <= evt_mod;
        r_idx <= '0;
        r_match <= 1'b0;
        r_free <= 1'b0;
      end
      if (r_state == S_SCAN) begin
        if (w_hit && !r_match) begin
          r_match <= 1'b1;
          r_match_idx <= r_idx;
        end
        if (w_vacant && !r_free) begin
          r_free <= 1'b1;
          r_free_idx <= r_idx;
        end
        r_idx <= r_idx + 1'b1;
      end
      if (r_state == S_COMMIT) begin
        if (r_on) begin
          carrier_out[int'(w_ch)*NUM_BITS +: NUM_BITS] <= r_car;
          modulator_out[int'(w_ch)*NUM_BITS +: NUM_BITS] <= r_mod;
          velocity_out[int'(w_ch)*NUM_BITS +: NUM_BITS] <= r_vel;
          r_note_tab[w_ch] <= r_note;
          gate_out[w_ch] <= 1'b1;
          if (!r_match && !r_free) begin
            steal_pulse <= 1'b1;
            r_steal_ptr <= r_steal_ptr == LAST ? '0 : r_steal_ptr + 1'b1;
          end
        end else if (r_match) begin
          // carrier/modulator stay put so the release tail keeps its pitch
          gate_out[r_match_idx] <= 1'b0;
          velocity_out[int'(r_match_idx)*NUM_BITS +: NUM_BITS] <= '0;
        end else miss_pulse <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed events with hand-computed expectations, checked by a
// scoreboard monitor whenever the allocator returns to ready.
module tb_voice_allocator;
  logic clk = 0, rst = 0;
  logic evt_valid = 0, evt_ready, evt_on = 0;
  logic [6:0] evt_note = 0;
  logic [31:0] evt_vel = 0, evt_car = 0, evt_mod = 0;
  logic [15:0] available = 16'hFFFF;
  logic [511:0] carrier_out, modulator_out, velocity_out;
  logic [15:0] gate_out;
  logic steal_pulse, miss_pulse;
  int passed = 0, total = 0, cyc = 0;
  typedef struct {
    logic [15:0] g;
    int ch;
    logic [31:0] v, c, m;
    bit st, ms;
    int acc;
  } exp_t;
  exp_t q[$];

  voice_allocator dut (
    .clk(clk), .rst(rst), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_on(evt_on), .evt_note(evt_note), .evt_vel(evt_vel), .evt_car(evt_car),
    .evt_mod(evt_mod), .available(available), .carrier_out(carrier_out),
    .modulator_out(modulator_out), .velocity_out(velocity_out), .gate_out(gate_out),
    .steal_pulse(steal_pulse), .miss_pulse(miss_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [31:0] car(input logic [6:0] n);
    return 32'hC000_0000 | 32'(n);
  endfunction
  function automatic logic [31:0] modw(input logic [6:0] n);
    return 32'hA000_0000 | 32'(n);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic send(input bit on, input logic [6:0] note, input logic [31:0] vel,
                      input int ch, input logic [15:0] g, input logic [31:0] ev,
                      input logic [31:0] ec, input logic [31:0] em, input bit st,
                      input bit ms, input bit push);
    for (int i = 0; i < 100 && !evt_ready; i++) @(negedge clk);
    if (!evt_ready) chk("ready_timeout", 0, 1);
    evt_on = on;
    evt_note = note;
    evt_vel = vel;
    evt_car = on ? car(note) : 32'hDEAD;
    evt_mod = on ? modw(note) : 32'hBEEF;
    evt_valid = 1;
    @(negedge clk);
    evt_valid = 0;
    evt_note = ~note;
    evt_vel = ~vel;
    evt_car = 32'h5555_5555;
    evt_mod = 32'h3333_3333;
    if (push) q.push_back('{g, ch, ev, ec, em, st, ms, cyc});
  endtask

  task automatic on_ok(input logic [6:0] n, input logic [31:0] v, input int ch,
                       input logic [15:0] g, input bit st);
    send(1, n, v, ch, g, v, car(n), modw(n), st, 0, 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) chk("drain_timeout", 64'(q.size()), 0);
    q.delete();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", evt_ready, 0);
    chk("rst_gate", gate_out, 0);
    chk("rst_buses", (carrier_out | modulator_out | velocity_out) == 0, 1);
    chk("rst_pulses", {steal_pulse, miss_pulse}, 0);
    rst = 1;
    @(negedge clk);
    chk("ready_after_release", evt_ready, 1);
  endtask

  // scoreboard monitor: an event completes when evt_ready rises
  initial begin
    automatic logic prev_ready = 0;
    automatic bit clr = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (clr) chk("pulses_one_cycle", {steal_pulse, miss_pulse}, 0);
      clr = 0;
      if (rst && evt_ready && !prev_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("latency", 64'(cyc - e.acc), 17);
        chk("gate", gate_out, e.g);
        chk("vel", velocity_out[e.ch*32 +: 32], e.v);
        chk("car", carrier_out[e.ch*32 +: 32], e.c);
        chk("mod", modulator_out[e.ch*32 +: 32], e.m);
        chk("steal_pulse", steal_pulse, e.st);
        chk("miss_pulse", miss_pulse, e.ms);
        clr = 1;
      end
      prev_ready = evt_ready;
    end
  end

  initial begin
    do_reset();
    on_ok(60, 32'h40, 0, 16'h0001, 0);
    on_ok(64, 32'h41, 1, 16'h0003, 0);
    on_ok(67, 32'h42, 2, 16'h0007, 0);
    available = 16'hFFFD;
    send(0, 64, 0, 1, 16'h0005, 0, car(64), modw(64), 0, 0, 1);
    on_ok(72, 32'h43, 3, 16'h000D, 0);
    wait_done();
    available = 16'hFFFF;
    do_reset();
    for (int i = 0; i < 16; i++)
      on_ok(7'(20 + i), 32'h10 + 32'(i), i, 16'((32'd1 << (i + 1)) - 1), 0);
    on_ok(90, 32'h55, 0, 16'hFFFF, 1);
    on_ok(91, 32'h56, 1, 16'hFFFF, 1);
    wait_done();
    do_reset();
    on_ok(60, 32'h20, 0, 16'h0001, 0);
    on_ok(60, 32'h7F, 0, 16'h0001, 0);
    send(0, 50, 0, 0, 16'h0001, 32'h7F, car(60), modw(60), 0, 1, 1);
    wait_done();
    do_reset();
    send(0, 50, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 1);
    wait_done();
    chk("miss_buses_zero", (carrier_out | modulator_out | velocity_out) == 0, 1);
    on_ok(60, 32'h11, 0, 16'h0001, 0);
    wait_done();
    send(1, 64, 32'h22, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    rst = 0;
    #1;
    chk("abort_gate", gate_out, 0);
    chk("abort_buses", (carrier_out | modulator_out | velocity_out) == 0, 1);
    chk("abort_ready", evt_ready, 0);
    @(negedge clk);
    rst = 1;
    on_ok(60, 32'h30, 0, 16'h0001, 0);
    wait_done();
    chk("queue_empty", 64'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
